nn_sequencer: RTL and testbench

- Upstream control stage for neural_network. Turns a host command stream and a data stream into the network's serial control and data signals: write_enable, input_select, layer, node and data_in.
- Runs two kinds of command:
  - weight load: streams weights into weight memory.
  - inference: feeds one input vector, steps all layers, then returns the LAYER_SIZE outputs on a result stream.
- One instance per neural_network. Host-facing interfaces are valid/ready.

---
 rtl/nn_pkg.sv | 31 +++
 rtl/nn_addr_counter.sv | 64 ++++++
 rtl/nn_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_nn_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and sizing helpers for the neural-network sequencer.
package nn_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CLEAR = 3'd2,
    FEED  = 3'd3,
    STEP  = 3'd4,
    DRAIN = 3'd5
  } seq_state_t;

  localparam int DEF_LAYER_SIZE  = 3;
  localparam int DEF_LAYER_DEPTH = 2;
  localparam int DEF_BIT_SIZE    = 8;

  localparam int WEIGHTS_PER_NODE = DEF_LAYER_SIZE;

  // Address width that stays at least one bit wide for single-entry dimensions
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NODE_ADDR_W  = addr_w(DEF_LAYER_SIZE);
  localparam int LAYER_ADDR_W = addr_w(DEF_LAYER_DEPTH);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/nn_addr_counter.sv
// Nested word/node/layer address counter shared by the LOAD, FEED and STEP phases.
module nn_addr_counter
  import nn_pkg::*;
#(
  parameter int W_COUNT     = WEIGHTS_PER_NODE,
  parameter int NODE_COUNT  = DEF_LAYER_SIZE,
  parameter int LAYER_COUNT = DEF_LAYER_DEPTH,
  parameter int W_W         = addr_w(W_COUNT),
  parameter int NODE_W      = addr_w(NODE_COUNT),
  parameter int LAYER_W     = addr_w(LAYER_COUNT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc_w,
  input  logic               inc_node,
  output logic [NODE_W-1:0]  node,
  output logic [LAYER_W-1:0] layer,
  output logic               w_last,
  output logic               node_last,
  output logic               layer_last
);

  logic [W_W-1:0] w_r;
  logic           node_step_s;
  logic           layer_step_s;

  assign w_last       = (w_r == W_W'(W_COUNT - 1));
  assign node_last    = (node == NODE_W'(NODE_COUNT - 1));
  assign layer_last   = (layer == LAYER_W'(LAYER_COUNT - 1));
  // inc_node advances the node directly; inc_w carries into node on word wrap
  assign node_step_s  = inc_node || (inc_w && w_last);
  assign layer_step_s = node_step_s && node_last;

  // Counter state with wrap on the last index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_r   <= W_W'(32'd0);
      node  <= NODE_W'(32'd0);
      layer <= LAYER_W'(32'd0);
    end else if (clr) begin
      w_r   <= W_W'(32'd0);
      node  <= NODE_W'(32'd0);
      layer <= LAYER_W'(32'd0);
    end else begin
      if (inc_w) begin
        w_r <= w_last ? W_W'(32'd0) : w_r + W_W'(32'd1);
      end else begin
        w_r <= w_r;
      end
      if (node_step_s) begin
        node <= node_last ? NODE_W'(32'd0) : node + NODE_W'(32'd1);
      end else begin
        node <= node;
      end
      if (layer_step_s) begin
        layer <= layer_last ? LAYER_W'(32'd0) : layer + LAYER_W'(32'd1);
      end else begin
        layer <= layer;
      end
    end
  end

endmodule

// File: rtl/nn_sequencer.sv
// Host command/data sequencer driving neural_network weight loads and inference.
// Optional cycle counter output perf_cycles is built when NN_SEQ_PERF_EN is defined.
module nn_sequencer
  import nn_pkg::*;
#(
  parameter int LAYER_SIZE  = DEF_LAYER_SIZE,
  parameter int LAYER_DEPTH = DEF_LAYER_DEPTH,
  parameter int BIT_SIZE    = DEF_BIT_SIZE
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_load,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [BIT_SIZE-1:0]              s_data,
  output logic                             nn_write_enable,
  output logic                             nn_input_select,
  output logic                             nn_clear,
  output logic [addr_w(LAYER_DEPTH)-1:0]   nn_layer,
  output logic [addr_w(LAYER_SIZE)-1:0]    nn_node,
  output logic [BIT_SIZE-1:0]              nn_data_in,
  input  logic [BIT_SIZE-1:0]              nn_y,
  output logic                             r_valid,
  input  logic                             r_ready,
  output logic [BIT_SIZE-1:0]              r_data
`ifdef NN_SEQ_PERF_EN
  ,
  output logic [31:0]                      perf_cycles
`endif
);

  localparam int  NODE_W      = addr_w(LAYER_SIZE);
  localparam int  LAYER_W     = addr_w(LAYER_DEPTH);
  localparam bit  MULTI_LAYER = (LAYER_DEPTH > 1);
  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(LAYER_DEPTH - 1);

  seq_state_t         state_r;
  seq_state_t         state_nxt_s;
  logic               cnt_clr_s;
  logic               cnt_inc_w_s;
  logic               cnt_inc_node_s;
  logic [NODE_W-1:0]  cnt_node_s;
  logic [LAYER_W-1:0] cnt_layer_s;
  logic               w_last_s;
  logic               node_last_s;
  logic               layer_last_s;
  logic               r_fire_s;
  logic               done_s;

  assign r_fire_s = r_valid && r_ready;
  assign done_s   = (state_r == DRAIN) && r_fire_s && node_last_s;

  nn_addr_counter #(
    .W_COUNT     (LAYER_SIZE),
    .NODE_COUNT  (LAYER_SIZE),
    .LAYER_COUNT (LAYER_DEPTH)
  ) u_addr (
    .clk        (clk),
    .rst        (rst),
    .clr        (cnt_clr_s),
    .inc_w      (cnt_inc_w_s),
    .inc_node   (cnt_inc_node_s),
    .node       (cnt_node_s),
    .layer      (cnt_layer_s),
    .w_last     (w_last_s),
    .node_last  (node_last_s),
    .layer_last (layer_last_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          state_nxt_s = cmd_load ? LOAD : CLEAR;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        if (s_valid && w_last_s && node_last_s && layer_last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = LOAD;
        end
      end
      CLEAR: state_nxt_s = FEED;
      FEED: begin
        if (s_valid && node_last_s) begin
          state_nxt_s = MULTI_LAYER ? STEP : DRAIN;
        end else begin
          state_nxt_s = FEED;
        end
      end
      STEP: begin
        if (node_last_s && layer_last_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = STEP;
        end
      end
      DRAIN: begin
        if (done_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Network/host strobes and counter control per state
  always_comb begin
    cmd_ready       = 1'b0;
    s_ready         = 1'b0;
    nn_write_enable = 1'b0;
    nn_input_select = 1'b0;
    nn_clear        = 1'b0;
    nn_data_in      = {BIT_SIZE{1'b0}};
    nn_node         = cnt_node_s;
    nn_layer        = cnt_layer_s;
    cnt_clr_s       = 1'b0;
    cnt_inc_w_s     = 1'b0;
    cnt_inc_node_s  = 1'b0;
    case (state_r)
      IDLE: begin
        cmd_ready = 1'b1;
        cnt_clr_s = cmd_valid;
      end
      LOAD: begin
        s_ready         = 1'b1;
        nn_write_enable = s_valid;
        cnt_inc_w_s     = s_valid;
        nn_data_in      = s_valid ? s_data : {BIT_SIZE{1'b0}};
      end
      CLEAR: begin
        nn_clear  = 1'b1;
        cnt_clr_s = 1'b1;
      end
      FEED: begin
        s_ready         = 1'b1;
        nn_input_select = 1'b1;
        cnt_inc_node_s  = s_valid;
        nn_data_in      = s_valid ? s_data : {BIT_SIZE{1'b0}};
      end
      STEP: begin
        cnt_inc_node_s = 1'b1;
      end
      DRAIN: begin
        // Results are read from the output layer; counter clears on the last word
        nn_layer = LAST_LAYER;
        if (r_fire_s) begin
          cnt_clr_s      = node_last_s;
          cnt_inc_node_s = !node_last_s;
        end else begin
          cnt_clr_s      = 1'b0;
          cnt_inc_node_s = 1'b0;
        end
      end
      default: begin
        cmd_ready = 1'b0;
      end
    endcase
  end

  // Result capture: nn_y is sampled at the edge closing the node-present cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= {BIT_SIZE{1'b0}};
    end else if ((state_r == DRAIN) && !r_valid) begin
      r_valid <= 1'b1;
      r_data  <= nn_y;
    end else if (r_fire_s) begin
      r_valid <= 1'b0;
      r_data  <= r_data;
    end else begin
      r_valid <= r_valid;
      r_data  <= r_data;
    end
  end

`ifdef NN_SEQ_PERF_EN
  logic [31:0] cyc_r;
  logic        busy_r;

  // Inference latency, counting both the command and final result handshake cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_r       <= 32'd0;
      busy_r      <= 1'b0;
      perf_cycles <= 32'd0;
    end else if ((state_r == IDLE) && cmd_valid && !cmd_load) begin
      cyc_r       <= 32'd1;
      busy_r      <= 1'b1;
      perf_cycles <= perf_cycles;
    end else if (busy_r && done_s) begin
      cyc_r       <= cyc_r;
      busy_r      <= 1'b0;
      perf_cycles <= sat_inc(cyc_r);
    end else if (busy_r) begin
      cyc_r       <= sat_inc(cyc_r);
      busy_r      <= 1'b1;
      perf_cycles <= perf_cycles;
    end else begin
      cyc_r       <= cyc_r;
      busy_r      <= busy_r;
      perf_cycles <= perf_cycles;
    end
  end
`endif

endmodule

// File: tb/tb_nn_sequencer.sv
// Directed/randomised bench for nn_sequencer; covers perf_cycles when NN_SEQ_PERF_EN is defined.
module tb_nn_sequencer;
  import nn_pkg::*;

  localparam int LS    = 3;
  localparam int LD    = 2;
  localparam int BW    = 8;
  localparam int NW    = addr_w(LS);
  localparam int LW    = addr_w(LD);
  localparam int TOTAL = LD * LS * LS;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_load = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [BW-1:0] s_data = 8'd0;
  logic          nn_write_enable;
  logic          nn_input_select;
  logic          nn_clear;
  logic [LW-1:0] nn_layer;
  logic [NW-1:0] nn_node;
  logic [BW-1:0] nn_data_in;
  logic [BW-1:0] nn_y;
  logic          r_valid;
  logic          r_ready = 1'b0;
  logic [BW-1:0] r_data;
`ifdef NN_SEQ_PERF_EN
  logic [31:0]   perf_cycles;
`endif

  logic [BW-1:0] y_base = 8'd0;
  logic [31:0]   exp_perf = 32'd0;
  int            n_assert = 0;
  int            n_fail = 0;

  // Network model: y of the presented node is base + node
  assign nn_y = y_base + BW'(nn_node);

  always #5 clk = ~clk;

  nn_sequencer #(.LAYER_SIZE(LS), .LAYER_DEPTH(LD), .BIT_SIZE(BW)) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_load        (cmd_load),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_data          (s_data),
    .nn_write_enable (nn_write_enable),
    .nn_input_select (nn_input_select),
    .nn_clear        (nn_clear),
    .nn_layer        (nn_layer),
    .nn_node         (nn_node),
    .nn_data_in      (nn_data_in),
    .nn_y            (nn_y),
    .r_valid         (r_valid),
    .r_ready         (r_ready),
    .r_data          (r_data)
`ifdef NN_SEQ_PERF_EN
    ,
    .perf_cycles     (perf_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_we"}, nn_write_enable, 0);
    chk({tag, "_sel"}, nn_input_select, 0);
    chk({tag, "_clear"}, nn_clear, 0);
    chk({tag, "_r_valid"}, r_valid, 0);
    chk({tag, "_layer"}, nn_layer, 0);
    chk({tag, "_node"}, nn_node, 0);
    chk({tag, "_data_in"}, nn_data_in, 0);
  endtask

  task automatic run_infer(input logic [BW-1:0] ybase, input int stall0, input bit hold_cmd);
    logic [BW-1:0] xin [LS];
    logic [BW-1:0] ey;
    int            stalls_left;
    bit            seen;
    bit            done;
    y_base = ybase;
    for (int k = 0; k < LS; k++) xin[k] = BW'($urandom);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_load = 1'b0; s_valid = 1'b0; r_ready = 1'b0;
    #1;
    chk("cmd_accept_ready", cmd_ready, 1);
`ifdef NN_SEQ_PERF_EN
    chk("perf_held", perf_cycles, exp_perf);
`endif
    @(negedge clk);
    cmd_valid = hold_cmd;
    #1;
    chk("clear_pulse", nn_clear, 1);
    chk("clear_layer", nn_layer, 0);
    chk("clear_node", nn_node, 0);
    chk("clear_cmd_ready", cmd_ready, 0);
    for (int k = 0; k < LS; k++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = xin[k];
      #1;
      chk("feed_sel", nn_input_select, 1);
      chk("feed_s_ready", s_ready, 1);
      chk("feed_node", nn_node, k);
      chk("feed_layer", nn_layer, 0);
      chk("feed_data", nn_data_in, xin[k]);
      chk("feed_clear", nn_clear, 0);
      chk("feed_we", nn_write_enable, 0);
      chk("feed_cmd_ready", cmd_ready, 0);
    end
    for (int k = 0; k < (LD - 1) * LS; k++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = BW'($urandom);
      #1;
      chk("step_sel", nn_input_select, 0);
      chk("step_s_ready", s_ready, 0);
      chk("step_we", nn_write_enable, 0);
      chk("step_layer", nn_layer, 1 + k / LS);
      chk("step_node", nn_node, k % LS);
      chk("step_cmd_ready", cmd_ready, 0);
    end
    stalls_left = stall0;
    for (int j = 0; j < LS; j++) begin
      seen = 1'b0;
      done = 1'b0;
      ey = ybase + BW'(j);
      for (int c = 0; c < 16 && !done; c++) begin
        @(negedge clk);
        s_valid = 1'b1;
        #1;
        chk("drain_cmd_ready", cmd_ready, 0);
        chk("drain_s_ready", s_ready, 0);
        if (seen) chk("drain_r_valid_hold", r_valid, 1);
        if (r_valid) begin
          seen = 1'b1;
          chk("drain_r_data", r_data, ey);
          if (stalls_left > 0) begin
            r_ready = 1'b0;
            stalls_left--;
          end else begin
            r_ready = 1'b1;
            done = 1'b1;
          end
        end else begin
          r_ready = 1'b1;
        end
      end
      chk("drain_word_done", done, 1);
    end
    exp_perf = 32'(2 + LS + (LD - 1) * LS + 2 * LS + stall0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [BW-1:0] wts [TOTAL];
    int beats;
    int pulses;

    // Reset state
    #2;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_r_data", r_data, 0);
    chk_quiet("rst");
`ifdef NN_SEQ_PERF_EN
    chk("rst_perf", perf_cycles, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Reset in the middle of a weight load
    @(negedge clk);
    cmd_valid = 1'b1; cmd_load = 1'b1;
    #1;
    chk("midload_cmd_ready", cmd_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0; s_valid = 1'b1; s_data = BW'($urandom);
      #1;
      chk("midload_we", nn_write_enable, 1);
    end
    #1;
    rst = 1'b0;
    #1;
    chk_quiet("midload_rst");
    chk("midload_rst_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0;
    #1;
    chk("midload_after_cmd_ready", cmd_ready, 1);
    chk("midload_after_s_ready", s_ready, 0);

    // Full weight load with s_valid toggling
    for (int i = 0; i < TOTAL; i++) wts[i] = BW'($urandom);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_load = 1'b1;
    #1;
    chk("load_cmd_ready", cmd_ready, 1);
    beats = 0;
    pulses = 0;
    for (int c = 0; c < 200 && beats < TOTAL; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0; s_valid = ((c % 2) == 1); s_data = wts[beats];
      #1;
      if (nn_write_enable) pulses++;
      if (s_valid && s_ready) begin
        chk("load_layer", nn_layer, beats / (LS * LS));
        chk("load_node", nn_node, (beats / LS) % LS);
        chk("load_data", nn_data_in, wts[beats]);
        chk("load_we", nn_write_enable, 1);
        beats++;
      end
    end
    chk("load_beats", beats, TOTAL);
    chk("load_pulses", pulses, TOTAL);
    @(negedge clk);
    s_valid = 1'b1; s_data = BW'($urandom);
    #1;
    chk("load_done_cmd_ready", cmd_ready, 1);
    chk("load_done_s_ready", s_ready, 0);
    chk("load_done_we", nn_write_enable, 0);
    s_valid = 1'b0;

    // Inferences: stalled drain with cmd held, back-to-back, then a released command
    run_infer(8'd10, 4, 1'b1);
    run_infer(BW'($urandom_range(0, 200)), 0, 1'b1);
    run_infer(BW'($urandom_range(0, 200)), 2, 1'b0);

    @(negedge clk);
    s_valid = 1'b0; r_ready = 1'b0;
    #1;
    chk("end_cmd_ready", cmd_ready, 1);
    chk("end_r_valid", r_valid, 0);
    chk("end_clear", nn_clear, 0);
`ifdef NN_SEQ_PERF_EN
    chk("end_perf", perf_cycles, exp_perf);
`endif
    repeat (4) @(negedge clk);
    #1;
    chk("end_idle_cmd_ready", cmd_ready, 1);
    chk("end_idle_s_ready", s_ready, 0);
`ifdef NN_SEQ_PERF_EN
    chk("end_perf_hold", perf_cycles, exp_perf);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
